// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multi-cycle multiply/divide unit.
// Holds funct3 decode, FSM encoding and operand-sign helpers.
package muldiv_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] FUNCT7_M = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CALC   = 2'd1;
   localparam logic [1:0] S_ADJUST = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   function automatic logic a_signed(input logic [2:0] f3);
      return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
   endfunction

   function automatic logic b_signed(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_if.sv
// Handshake bundle between the execute stage and the mul/div unit.
// master = pipeline side, slave = mul/div controller.
interface ex_muldiv_ctrl_if
   import muldiv_pkg::*;
   #(parameter int XLEN = XLEN_DEF);

   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] opA;
   logic [XLEN-1:0] opB;
   logic [4:0]      rdIn;
   logic            kill;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rdOut;

   modport master (
      output start, funct3, opA, opB, rdIn, kill,
      input  stall, busy, done, result, rdOut
   );

   modport slave (
      input  start, funct3, opA, opB, rdIn, kill,
      output stall, busy, done, result, rdOut
   );

endinterface

// File: rtl/muldiv_iter_core.sv
// Iteration datapath: shift-add multiply or restoring divide on magnitudes.
// hi/lo hold product halves, or remainder/quotient when dividing.
module muldiv_iter_core
   import muldiv_pkg::*;
   #(parameter int XLEN = XLEN_DEF)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            step,
   input  logic            is_div,
   input  logic [XLEN-1:0] mag_a,
   input  logic [XLEN-1:0] mag_b,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   logic [XLEN-1:0] hi_q, lo_q, b_q;
   logic [XLEN-1:0] hi_n, lo_n;
   logic [XLEN:0]   sum, trial, diff;

   // One shift-add or restoring-subtract step.
   always_comb begin
      hi_n  = hi_q;
      lo_n  = lo_q;
      sum   = {1'b0, hi_q} + {1'b0, b_q};
      trial = {hi_q, lo_q[XLEN-1]};
      diff  = trial - {1'b0, b_q};
      if (is_div) begin
         if (!diff[XLEN]) begin
            hi_n = diff[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_n = trial[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], 1'b0};
         end
      end else if (lo_q[0]) begin
         {hi_n, lo_n} = {sum, lo_q[XLEN-1:1]};
      end else begin
         {hi_n, lo_n} = {1'b0, hi_q, lo_q[XLEN-1:1]};
      end
   end

   // Load magnitudes on accept, then iterate while stepping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
         b_q  <= '0;
      end else if (load) begin
         hi_q <= '0;
         lo_q <= mag_a;
         b_q  <= mag_b;
      end else if (step) begin
         hi_q <= hi_n;
         lo_q <= lo_n;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M sequencer: FSM, sign handling, special cases and result registers.
// Stalls the front end while the iteration core runs.
module ex_muldiv_ctrl
   import muldiv_pkg::*;
   #(parameter int XLEN = XLEN_DEF)
(
   input  logic             clk,
   input  logic             rst,
   ex_muldiv_ctrl_if.slave  bus
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic [2:0]      f3_q;
   logic [4:0]      rd_q;
   logic            sa_q, sb_q;
   logic            done_q;
   logic [XLEN-1:0] res_q;
   logic [4:0]      rd_out_q;

   logic            accept, sa_in, sb_in, is_div_in;
   logic            div0, ovf, special;
   logic [XLEN-1:0] mag_a, mag_b, spec_res, adj_res;
   logic [XLEN-1:0] hi, lo, quo_s, rem_s;
   logic [2*XLEN-1:0] prod_s;

   // Accept decode, operand magnitudes and RISC-V divide corner cases.
   always_comb begin
      accept = bus.start & ~bus.kill &
               ((state == S_IDLE) | (state == S_DONE));
      sa_in     = a_signed(bus.funct3) & bus.opA[XLEN-1];
      sb_in     = b_signed(bus.funct3) & bus.opB[XLEN-1];
      mag_a     = sa_in ? -bus.opA : bus.opA;
      mag_b     = sb_in ? -bus.opB : bus.opB;
      is_div_in = bus.funct3[2];
      div0      = is_div_in & (bus.opB == '0);
      ovf       = is_div_in & ~bus.funct3[0] &
                  (bus.opA == MIN_NEG) & (bus.opB == '1);
      special   = div0 | ovf;
      if (div0) spec_res = bus.funct3[1] ? bus.opA : '1;
      else      spec_res = bus.funct3[1] ? '0 : MIN_NEG;
   end

   // Sign fix-up and half selection applied in ADJUST.
   always_comb begin
      prod_s = (sa_q ^ sb_q) ? -{hi, lo} : {hi, lo};
      quo_s  = (sa_q ^ sb_q) ? -lo : lo;
      rem_s  = sa_q ? -hi : hi;
      adj_res = '0;
      unique case (1'b1)
         f3_q[2] &  f3_q[1]:      adj_res = rem_s;
         f3_q[2] & ~f3_q[1]:      adj_res = quo_s;
         ~f3_q[2] & (f3_q[1:0] == 2'd0):
            adj_res = prod_s[XLEN-1:0];
         ~f3_q[2] & (f3_q[1:0] != 2'd0):
            adj_res = prod_s[2*XLEN-1:XLEN];
      endcase
   end

   muldiv_iter_core #(.XLEN(XLEN)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .step   (state == S_CALC),
      .is_div (f3_q[2]),
      .mag_a  (mag_a),
      .mag_b  (mag_b),
      .hi     (hi),
      .lo     (lo)
   );

   // FSM, iteration counter, op latches and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         f3_q     <= '0;
         rd_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         done_q   <= 1'b0;
         res_q    <= '0;
         rd_out_q <= '0;
      end else if (bus.kill) begin
         state  <= S_IDLE;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            S_IDLE, S_DONE: begin
               state <= S_IDLE;
               if (accept) begin
                  f3_q <= bus.funct3;
                  rd_q <= bus.rdIn;
                  sa_q <= sa_in;
                  sb_q <= sb_in;
                  cnt  <= '0;
                  if (special) begin
                     res_q    <= spec_res;
                     rd_out_q <= bus.rdIn;
                     done_q   <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) state <= S_ADJUST;
            end
            S_ADJUST: begin
               res_q    <= adj_res;
               rd_out_q <= rd_q;
               done_q   <= 1'b1;
               state    <= S_DONE;
            end
         endcase
      end
   end

   assign bus.stall  = accept | (state == S_CALC) | (state == S_ADJUST);
   assign bus.busy   = (state != S_IDLE);
   assign bus.done   = done_q;
   assign bus.result = res_q;
   assign bus.rdOut  = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: latency, results, kill, reset,
// and back-to-back issue.
module tb_ex_muldiv_ctrl;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ex_muldiv_ctrl_if bus ();

   ex_muldiv_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      bus.funct3 = f3;
      bus.opA    = a;
      bus.opB    = b;
      bus.rdIn   = rd;
      bus.start  = 1'b1;
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp,
                         input int lat);
      int cyc;
      logic got, stall_ok;
      @(negedge clk);
      drive(f3, a, b, rd);
      #1 chk({tag, "_stall_c0"}, bus.stall, 1'b1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      cyc = 0;
      got = 1'b0;
      stall_ok = 1'b1;
      while (cyc < 60 && !got) begin
         @(negedge clk);
         cyc++;
         if (bus.done) got = 1'b1;
         else if (!bus.stall) stall_ok = 1'b0;
      end
      chk({tag, "_latency"}, cyc, lat);
      chk({tag, "_result"}, bus.result, exp);
      chk({tag, "_rdOut"}, bus.rdOut, rd);
      chk({tag, "_stall_held"}, stall_ok, 1'b1);
      chk({tag, "_stall_done"}, bus.stall, 1'b0);
      @(negedge clk);
      chk({tag, "_done_pulse"}, bus.done, 1'b0);
   endtask

   initial begin
      int cyc;
      logic seen;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.kill   = 1'b0;
      bus.funct3 = '0;
      bus.opA    = '0;
      bus.opB    = '0;
      bus.rdIn   = '0;
      #12;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_stall", bus.stall, 1'b0);
      chk("rst_result", bus.result, 32'h0);
      chk("rst_rdOut", bus.rdOut, 5'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("mul", F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 34);
      run_op("mulhu", F3_MULHU, '1, '1, 5'd6, 32'hFFFFFFFE, 34);
      run_op("mulh", F3_MULH, '1, '1, 5'd7, 32'h00000000, 34);
      run_op("mulhsu", F3_MULHSU, '1, '1, 5'd8, 32'hFFFFFFFF, 34);
      run_op("divu", F3_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 34);
      run_op("remu", F3_REMU, 32'd100, 32'd7, 5'd10, 32'd2, 34);
      run_op("div_neg", F3_DIV, 32'hFFFFFFF9, 32'd2, 5'd11,
             32'hFFFFFFFD, 34);
      run_op("rem_neg", F3_REM, 32'hFFFFFFF9, 32'd2, 5'd12,
             32'hFFFFFFFF, 34);

      @(negedge clk);
      drive(F3_DIVU, 32'd100, 32'd7, 5'd13);
      @(posedge clk);
      #1 bus.start = 1'b0;
      seen = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      bus.kill = 1'b1;
      @(posedge clk);
      #1 bus.kill = 1'b0;
      @(negedge clk);
      chk("kill_busy", bus.busy, 1'b0);
      chk("kill_stall", bus.stall, 1'b0);
      chk("kill_done", bus.done | seen, 1'b0);
      chk("kill_result_kept", bus.result, 32'hFFFFFFFF);
      chk("kill_rd_kept", bus.rdOut, 5'd12);
      run_op("after_kill", F3_DIVU, 32'd100, 32'd7, 5'd14, 32'd14, 34);

      run_op("div_ovf", F3_DIV, 32'h80000000, '1, 5'd15,
             32'h80000000, 1);
      run_op("rem_ovf", F3_REM, 32'h80000000, '1, 5'd16, 32'h0, 1);
      run_op("div_zero", F3_DIV, 32'd100, 32'd0, 5'd17, '1, 1);
      run_op("rem_zero", F3_REM, 32'd100, 32'd0, 5'd18, 32'd100, 1);

      @(negedge clk);
      drive(F3_MUL, 32'd7, 32'd9, 5'd19);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_stall", bus.stall, 1'b0);
      chk("arst_done", bus.done, 1'b0);
      chk("arst_result", bus.result, 32'h0);
      chk("arst_rdOut", bus.rdOut, 5'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      chk("arst_no_done", seen, 1'b0);

      @(negedge clk);
      drive(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd3);
      cyc = 0;
      seen = 1'b0;
      while (cyc < 60 && !seen) begin
         @(negedge clk);
         cyc++;
         seen = bus.done;
      end
      chk("b2b_lat1", cyc, 34);
      chk("b2b_res1", bus.result, 32'hFFFFFFEB);
      drive(F3_DIVU, 32'd100, 32'd7, 5'd4);
      #1 chk("b2b_stall_done", bus.stall, 1'b1);
      @(posedge clk);
      #1 bus.start = 1'b0;
      cyc = 0;
      seen = 1'b0;
      while (cyc < 60 && !seen) begin
         @(negedge clk);
         cyc++;
         seen = bus.done;
      end
      chk("b2b_lat2", cyc, 34);
      chk("b2b_res2", bus.result, 32'd14);
      chk("b2b_rd2", bus.rdOut, 5'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
